// File: rtl/pattern_seq_misr.sv
// pattern_seq_misr: exhaustive pattern driver and MISR response compactor
// for a gate under test. Pattern k is driven as binary k on pattin, the GUT
// response on pattout is folded into the signature once per pattern, and the
// run ends in DONE with the signature held for comparison against the
// good-machine value.
module pattern_seq_misr #(
    parameter int               PAT_W    = 2,
    parameter int               RSP_W    = 1,
    parameter int               NUM_PATS = 4,
    parameter int               SETTLE   = 1,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = 16'h1021,
    parameter logic [SIG_W-1:0] SEED     = {SIG_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [PAT_W-1:0] pattin,
    input  logic [RSP_W-1:0] pattout,
    output logic             busy,
    output logic             sample_valid,
    output logic [PAT_W:0]   pat_index,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    // Settle counter is at least one bit wide even when SETTLE is 0.
    localparam int CNT_W = (SETTLE > 32'sd1) ? $clog2(SETTLE + 32'sd1) : 32'sd1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        CNT_W'((SETTLE > 32'sd0) ? (SETTLE - 32'sd1) : 32'sd0);
    localparam logic [PAT_W:0] LAST_IDX = (PAT_W + 1)'(NUM_PATS - 32'sd1);
    localparam bit HAS_SETTLE = (SETTLE > 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    state_t           state_nom_s;
    logic [CNT_W-1:0] settle_cnt_r;
    logic [PAT_W:0]   pat_index_r;
    logic [PAT_W-1:0] pattin_r;
    logic [SIG_W-1:0] sig_r;
    logic             busy_r;
    logic             sample_valid_r;
    logic             done_r;
    logic             launch_s;
    logic             apply_s;
    logic             capture_s;

    // One MISR step: shift left, fold MSB back through the taps, xor in the
    // zero-extended response. The feedback uses an AND mask rather than a
    // branch so an unknown MSB stays unknown instead of being masked.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [RSP_W-1:0] rsp
    );
        logic [SIG_W-1:0] rsp_ext;
        logic [SIG_W-1:0] fb;
        rsp_ext              = {SIG_W{1'b0}};
        rsp_ext[RSP_W-1:0]   = rsp;
        fb                   = POLY & {SIG_W{sig[SIG_W-1]}};
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ rsp_ext;
    endfunction

    // Next-state selection and per-cycle action strobes; abort overrides everything.
    always_comb begin
        state_nom_s = state_r;
        state_s     = state_r;
        launch_s    = 1'b0;
        apply_s     = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nom_s = ST_APPLY;
                end else begin
                    state_nom_s = state_r;
                end
            end
            ST_APPLY: begin
                if (HAS_SETTLE) begin
                    state_nom_s = ST_SETTLE;
                end else begin
                    state_nom_s = ST_CAPTURE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == {CNT_W{1'b0}}) begin
                    state_nom_s = ST_CAPTURE;
                end else begin
                    state_nom_s = ST_SETTLE;
                end
            end
            ST_CAPTURE: begin
                if (pat_index_r == LAST_IDX) begin
                    state_nom_s = ST_DONE;
                end else begin
                    state_nom_s = ST_APPLY;
                end
            end
            default: begin
                state_nom_s = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            state_s   = state_nom_s;
            launch_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
            apply_s   = (state_r == ST_APPLY);
            capture_s = (state_r == ST_CAPTURE);
        end
    end

    // State register and registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            sample_valid_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            busy_r         <= (state_s == ST_APPLY) || (state_s == ST_SETTLE) ||
                              (state_s == ST_CAPTURE);
            sample_valid_r <= (state_s == ST_CAPTURE);
            done_r         <= (state_s == ST_DONE);
        end
    end

    // Pattern index, driven pattern and signature; all hold across abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_index_r <= {(PAT_W + 1){1'b0}};
            pattin_r    <= {PAT_W{1'b0}};
            sig_r       <= {SIG_W{1'b0}};
        end else begin
            if (launch_s) begin
                pat_index_r <= {(PAT_W + 1){1'b0}};
                sig_r       <= SEED;
            end else if (capture_s) begin
                sig_r <= misr_step(sig_r, pattout);
                if (pat_index_r != LAST_IDX) begin
                    pat_index_r <= pat_index_r + {{PAT_W{1'b0}}, 1'b1};
                end else begin
                    pat_index_r <= pat_index_r;
                end
            end else begin
                sig_r       <= sig_r;
                pat_index_r <= pat_index_r;
            end
            if (apply_s) begin
                pattin_r <= pat_index_r[PAT_W-1:0];
            end else begin
                pattin_r <= pattin_r;
            end
        end
    end

    // Settle down-counter: loaded on entry to SETTLE, leaves at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_s == ST_SETTLE) && (state_r != ST_SETTLE)) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == ST_SETTLE) && (settle_cnt_r != {CNT_W{1'b0}})) begin
            settle_cnt_r <= settle_cnt_r - {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    assign pattin       = pattin_r;
    assign busy         = busy_r;
    assign sample_valid = sample_valid_r;
    assign pat_index    = pat_index_r;
    assign done         = done_r;
    assign signature    = sig_r;

endmodule

// File: tb/tb_pattern_seq_misr.sv
// Scoreboard bench for pattern_seq_misr. Three instances cover the 8-bit
// SETTLE=1 config (inst 0), the 4-bit MSB-feedback config (inst 1) and the
// SETTLE=0 config (inst 2). Drivers push expected samples and final
// signatures; one monitor pops and compares whenever a DUT presents them.
module tb_pattern_seq_misr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic [2:0] start_v;
    logic       mode_a;

    logic [1:0] pattin_a, pattin_b, pattin_c;
    logic       pattout_a, pattout_b, pattout_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic [7:0] sig_a, sig_c;
    logic [3:0] sig_b;
    logic [2:0] sv_v, done_v, busy_v;
    logic [1:0] pin_v [3];
    logic [2:0] idx_v [3];
    logic [7:0] sig_v [3];

    always #5 clk = ~clk;

    assign pattout_a = mode_a ? 1'b1 : pattin_a[1];
    assign pattout_b = 1'b1;
    assign pattout_c = pattin_c[1];

    pattern_seq_misr #(.PAT_W(2), .RSP_W(1), .NUM_PATS(4), .SETTLE(1), .SIG_W(8),
                       .POLY(8'h1D), .SEED(8'h00)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
        .pattin(pattin_a), .pattout(pattout_a), .busy(busy_v[0]),
        .sample_valid(sv_v[0]), .pat_index(idx_a), .done(done_v[0]), .signature(sig_a));

    pattern_seq_misr #(.PAT_W(2), .RSP_W(1), .NUM_PATS(1), .SETTLE(1), .SIG_W(4),
                       .POLY(4'h3), .SEED(4'h8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
        .pattin(pattin_b), .pattout(pattout_b), .busy(busy_v[1]),
        .sample_valid(sv_v[1]), .pat_index(idx_b), .done(done_v[1]), .signature(sig_b));

    pattern_seq_misr #(.PAT_W(2), .RSP_W(1), .NUM_PATS(4), .SETTLE(0), .SIG_W(8),
                       .POLY(8'h1D), .SEED(8'h00)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
        .pattin(pattin_c), .pattout(pattout_c), .busy(busy_v[2]),
        .sample_valid(sv_v[2]), .pat_index(idx_c), .done(done_v[2]), .signature(sig_c));

    assign pin_v[0] = pattin_a;  assign pin_v[1] = pattin_b;  assign pin_v[2] = pattin_c;
    assign idx_v[0] = idx_a;     assign idx_v[1] = idx_b;     assign idx_v[2] = idx_c;
    assign sig_v[0] = sig_a;     assign sig_v[1] = {4'h0, sig_b}; assign sig_v[2] = sig_c;

    typedef struct { int inst; logic [1:0] pat; logic [2:0] idx; int ofs; } samp_t;
    typedef struct { int inst; logic [7:0] sig; int ofs; } fin_t;

    samp_t samp_q[$];
    fin_t  fin_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    start_cyc [3];
    logic [2:0] done_prev = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Edge counter used to time samples and done against the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare whenever a DUT presents a sample or finishes.
    always @(negedge clk) begin
        samp_t s;
        fin_t  f;
        for (int i = 0; i < 3; i++) begin
            if (sv_v[i] === 1'b1) begin
                if (samp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_sample inst=%0d actual=1 expected=0", i);
                end else begin
                    s = samp_q.pop_front();
                    chk("samp_inst", i, s.inst);
                    chk("samp_pattin", {30'd0, pin_v[i]}, {30'd0, s.pat});
                    chk("samp_index", {29'd0, idx_v[i]}, {29'd0, s.idx});
                    chk("samp_offset", cyc - start_cyc[i] - 1, s.ofs);
                end
            end
            if ((done_v[i] === 1'b1) && !done_prev[i]) begin
                if (fin_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done inst=%0d actual=1 expected=0", i);
                end else begin
                    f = fin_q.pop_front();
                    chk("done_inst", i, f.inst);
                    chk("done_signature", {24'd0, sig_v[i]}, {24'd0, f.sig});
                    chk("done_latency", cyc - start_cyc[i] - 1, f.ofs);
                    chk("done_busy", {31'd0, busy_v[i]}, 32'd0);
                end
            end
        end
        done_prev <= done_v;
    end

    // Push expectations for a run, then pulse start for one cycle.
    task automatic run(input int i, input int npat, input int settle,
                       input logic [7:0] sig, input int npush);
        for (int k = 0; k < npush; k++) begin
            samp_q.push_back('{i, 2'(k), 3'(k), k * (2 + settle) + 1 + settle});
        end
        if (npush == npat) fin_q.push_back('{i, sig, npat * (2 + settle)});
        @(negedge clk);
        start_cyc[i] = cyc;
        start_v[i]   = 1'b1;
        @(negedge clk);
        start_v[i]   = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit);
        int n = 0;
        while ((done_v[i] !== 1'b1) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_v[i] !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout inst=%0d actual=0 expected=1", i);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_samples(input int i, input int n, input int limit);
        int seen = 0;
        int t = 0;
        while ((seen < n) && (t < limit)) begin
            @(negedge clk);
            t++;
            if (sv_v[i] === 1'b1) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL sample_timeout inst=%0d actual=%0d expected=%0d", i, seen, n);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_busy"},   {31'd0, busy_v[i]}, 32'd0);
        chk({tag, "_sv"},     {31'd0, sv_v[i]},   32'd0);
        chk({tag, "_done"},   {31'd0, done_v[i]}, 32'd0);
        chk({tag, "_pattin"}, {30'd0, pin_v[i]},  32'd0);
        chk({tag, "_index"},  {29'd0, idx_v[i]},  32'd0);
        chk({tag, "_sig"},    {24'd0, sig_v[i]},  32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        abort   = 1'b0;
        start_v = 3'b000;
        mode_a  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // pattout = pattin[1]: responses 0,0,1,1 -> 8'h03 after 12 edges
        run(0, 4, 1, 8'h03, 4);
        wait_done(0, 40);

        // pattout tied 1: 1,3,7,F
        mode_a = 1'b1;
        run(0, 4, 1, 8'h0F, 4);
        wait_done(0, 40);

        // 4-bit, seed 8, one pattern: 8 -> 0 ^ 3 ^ 1 = 2
        run(1, 1, 1, 8'h02, 1);
        wait_done(1, 20);

        // SETTLE=0 with start re-pulsed while busy
        run(2, 4, 0, 8'h03, 4);
        repeat (2) @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        wait_done(2, 40);

        // abort after the second sample: responses 1,1 give 8'h03, pattin stays 1
        run(0, 4, 1, 8'h00, 2);
        wait_samples(0, 2, 20);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",   {31'd0, busy_v[0]}, 32'd0);
        chk("abort_done",   {31'd0, done_v[0]}, 32'd0);
        chk("abort_sig",    {24'd0, sig_a},     32'h03);
        chk("abort_pattin", {30'd0, pattin_a},  32'd1);
        repeat (6) @(negedge clk);
        chk("abort_done_held", {31'd0, done_v[0]}, 32'd0);
        chk("abort_busy_held", {31'd0, busy_v[0]}, 32'd0);
        mode_a = 1'b0;
        run(0, 4, 1, 8'h03, 4);
        wait_done(0, 40);

        // async reset in SETTLE of pattern 2, then a clean run
        mode_a = 1'b1;
        run(0, 4, 1, 8'h00, 2);
        wait_samples(0, 2, 20);
        repeat (2) @(negedge clk);
        chk("pre_reset_busy",   {31'd0, busy_v[0]}, 32'd1);
        chk("pre_reset_pattin", {30'd0, pattin_a},  32'd2);
        chk("pre_reset_sig",    {24'd0, sig_a},     32'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midrun_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mode_a = 1'b0;
        run(0, 4, 1, 8'h03, 4);
        wait_done(0, 40);

        chk("leftover_samples", samp_q.size(), 32'd0);
        chk("leftover_finals",  fin_q.size(),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
